rf_wb_arbiter: RTL



---
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 4x16 register file: round-robin ALU/MEM grant, registered write port,
// pending-write scoreboard with RAW hazard flag. Optional forwarding outputs under `WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [AW-1:0]         alu_addr,
  input  logic [DW-1:0]         alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_data,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  input  logic [AW-1:0]         rd_addr1,
  input  logic [AW-1:0]         rd_addr2,
  output logic                  hazard,
  output logic [(1<<AW)-1:0]    busy,
  output logic                  issue_conflict,
`ifdef WB_BYPASS_EN
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [DW-1:0]         byp_data,
`endif
  output logic                  rf_write,
  output logic [AW-1:0]         rf_addr,
  output logic [DW-1:0]         rf_data
);

  localparam int NREG = 1 << AW;

  // Handshake: a source's request completes in any cycle where its valid and ready are both 1.
  // Ready is a pure function of the valids and the round-robin pointer; a source that is not
  // granted must hold valid/addr/data until it is.
  logic                r_last_mem;
  logic                r_rf_write;
  logic [AW-1:0]       r_rf_addr;
  logic [DW-1:0]       r_rf_data;
  logic [NREG-1:0]     r_busy;
  logic                r_issue_conflict;

  logic                w_grant_alu;
  logic                w_grant_mem;
  logic [NREG-1:0]     w_set_vec;
  logic [NREG-1:0]     w_clr_vec;
  logic [NREG-1:0]     w_busy_next;
  logic                w_conflict_next;
  logic [NREG-1:0]     w_hazard_vec;

  always_comb begin
    w_grant_alu = alu_valid & (~mem_valid | r_last_mem);
    w_grant_mem = mem_valid & (~alu_valid | ~r_last_mem);
  end

  assign alu_ready = w_grant_alu;
  assign mem_ready = w_grant_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_mem <= 1'b1;
    end else if (w_grant_alu) begin
      r_last_mem <= 1'b0;
    end else if (w_grant_mem) begin
      r_last_mem <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_write <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
    end else begin
      r_rf_write <= w_grant_alu | w_grant_mem;
      if (w_grant_alu) begin
        r_rf_addr <= alu_addr;
        r_rf_data <= alu_data;
      end else if (w_grant_mem) begin
        r_rf_addr <= mem_addr;
        r_rf_data <= mem_data;
      end
    end
  end

  // Set is OR-ed in after the clear so a same-edge re-issue keeps the register pending.
  always_comb begin
    w_set_vec       = issue_valid ? ({{(NREG-1){1'b0}}, 1'b1} << issue_addr) : '0;
    w_clr_vec       = r_rf_write  ? ({{(NREG-1){1'b0}}, 1'b1} << r_rf_addr)  : '0;
    w_busy_next     = (r_busy & ~w_clr_vec) | w_set_vec;
    w_conflict_next = issue_valid & r_busy[issue_addr] & ~w_clr_vec[issue_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy           <= '0;
      r_issue_conflict <= 1'b0;
    end else begin
      r_busy           <= w_busy_next;
      r_issue_conflict <= w_conflict_next;
    end
  end

`ifdef WB_BYPASS_EN
  // The register being written this cycle is forwarded, so it does not stall decode.
  assign w_hazard_vec = r_busy & ~w_clr_vec;
  assign byp1_hit     = r_rf_write & (r_rf_addr == rd_addr1);
  assign byp2_hit     = r_rf_write & (r_rf_addr == rd_addr2);
  assign byp_data     = r_rf_data;
`else
  assign w_hazard_vec = r_busy;
`endif

  assign hazard         = w_hazard_vec[rd_addr1] | w_hazard_vec[rd_addr2];
  assign busy           = r_busy;
  assign issue_conflict = r_issue_conflict;
  assign rf_write       = r_rf_write;
  assign rf_addr        = r_rf_addr;
  assign rf_data        = r_rf_data;

endmodule
